spi_reg_bridge: RTL and testbench

- Byte-level protocol engine directly downstream of spi_slave, running in the same clk domain.
- Consumes spi_slave's request pulse and received byte (dout); produces the next byte to shift out (din).
- Decodes a command byte and turns the SPI stream into register-bus reads and writes with auto-incrementing address.
- Gives host software register access over SPI.

---
 rtl/spi_reg_bridge_pkg.sv | 15 +
 rtl/spi_reg_bridge_if.sv | 26 ++
 rtl/spi_reg_bridge.sv | 98 +++++++++
 tb/tb_spi_reg_bridge.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_bridge_pkg.sv
// Shared definitions for the SPI-to-register-bus bridge: FSM states,
// command bit position and the default status byte.
package spi_reg_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_READ
    } state_t;

    localparam int unsigned  CMD_READ_BIT   = 7;
    localparam logic [7:0]   STATUS_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Register bus between the bridge (master) and a register file (slave).
interface spi_reg_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic                  reg_we;
    logic [7:0]            reg_wdata;
    logic                  reg_re;
    logic [7:0]            reg_rdata;

    modport master (
        output reg_addr,
        output reg_we,
        output reg_wdata,
        output reg_re,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_we,
        input  reg_wdata,
        input  reg_re,
        output reg_rdata
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// Byte-level protocol engine behind spi_slave: decodes a command byte and
// turns the SPI byte stream into auto-incrementing register reads/writes.
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter logic [7:0]  STATUS     = STATUS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                select,
    input  logic                request,
    input  logic [7:0]          rx_byte,
    output logic [7:0]          tx_byte,
    output logic                active,
    spi_reg_bridge_if.master    bus
);

    // The address lives in cmd[6:0], so it cannot be wider than 7 bits.
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 7) begin : g_bad_addr_width
        $error("spi_reg_bridge: ADDR_WIDTH must be 1..7");
    end

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            tx_d;
    logic                  active_d;
    logic [ADDR_WIDTH-1:0] rx_addr;

    assign rx_addr       = rx_byte[ADDR_WIDTH-1:0];
    assign bus.reg_wdata = rx_byte;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            tx_byte <= '0;
            active  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tx_byte <= tx_d;
            active  <= active_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        tx_d         = tx_byte;
        active_d     = active;
        bus.reg_addr = addr_q;
        bus.reg_we   = 1'b0;
        bus.reg_re   = 1'b0;

        // Deselect overrides a coincident request: no bus access, back to IDLE.
        if (!select) begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
        end else if (request) begin
            unique case (state_q)
                ST_IDLE: begin
                    tx_d    = STATUS;
                    state_d = ST_CMD;
                end
                ST_CMD: begin
                    active_d = 1'b1;
                    addr_d   = rx_addr;
                    if (rx_byte[CMD_READ_BIT]) begin
                        bus.reg_addr = rx_addr;
                        bus.reg_re   = 1'b1;
                        tx_d         = bus.reg_rdata;
                        addr_d       = rx_addr + ADDR_ONE;
                        state_d      = ST_READ;
                    end else begin
                        tx_d    = rx_byte;
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    bus.reg_we = 1'b1;
                    tx_d       = rx_byte;
                    addr_d     = addr_q + ADDR_ONE;
                end
                ST_READ: begin
                    // Last request of a burst prefetches a byte that is never shifted out.
                    bus.reg_re = 1'b1;
                    tx_d       = bus.reg_rdata;
                    addr_d     = addr_q + ADDR_ONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench: byte-level spi_slave stand-in, 128x8 register array,
// hand-computed expectations checked with immediate assertions.
module tb_spi_reg_bridge;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       select;
    logic       request;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       active;

    int n_assert = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int re_cnt   = 0;
    int we0, re0;
    logic [7:0] m;

    logic [7:0] regs [128] = '{default: 8'h00};

    spi_reg_bridge_if #(.ADDR_WIDTH(7)) bus ();

    spi_reg_bridge #(.ADDR_WIDTH(7), .STATUS(8'hA5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .select  (select),
        .request (request),
        .rx_byte (rx_byte),
        .tx_byte (tx_byte),
        .active  (active),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always_comb bus.reg_rdata = regs[bus.reg_addr];

    always @(posedge clk) begin
        if (bus.reg_we) begin
            regs[bus.reg_addr] <= bus.reg_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (bus.reg_re) re_cnt <= re_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] b);
        @(negedge clk);
        request = 1'b1;
        rx_byte = b;
        @(negedge clk);
        request = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic begin_txn();
        @(negedge clk);
        select = 1'b1;
        pulse(8'h5A);
    endtask

    task automatic end_txn();
        @(negedge clk);
        select = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Byte-level exchange: MISO is the byte registered at the previous request.
    task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso);
        repeat (3) @(negedge clk);
        miso = tx_byte;
        pulse(mosi);
    endtask

    initial begin
        reset_n = 1'b0;
        select  = 1'b0;
        request = 1'b0;
        rx_byte = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_tx", 32'(tx_byte), 32'h00);
        check("rst_active", 32'(active), 32'h0);
        check("rst_we", 32'(bus.reg_we), 32'h0);
        check("rst_re", 32'(bus.reg_re), 32'h0);
        check("rst_addr", 32'(bus.reg_addr), 32'h00);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write burst: cmd 05, data 11, 22.
        we0 = we_cnt;
        begin_txn();
        xfer(8'h05, m); check("wr_miso0", 32'(m), 32'hA5);
        xfer(8'h11, m); check("wr_miso1", 32'(m), 32'h05);
        check("wr_active", 32'(active), 32'h1);
        xfer(8'h22, m); check("wr_miso2", 32'(m), 32'h11);
        end_txn();
        check("wr_reg5", 32'(regs[5]), 32'h11);
        check("wr_reg6", 32'(regs[6]), 32'h22);
        check("wr_we_cnt", 32'(we_cnt - we0), 32'd2);
        check("wr_idle_active", 32'(active), 32'h0);
        check("wr_idle_addr", 32'(bus.reg_addr), 32'h07);

        // Preload regs[10]/[11] over the bus.
        begin_txn();
        xfer(8'h0A, m);
        xfer(8'h3C, m);
        xfer(8'h4D, m);
        end_txn();

        // Read burst: cmd 8A, two dummy bytes; one extra prefetch read expected.
        we0 = we_cnt;
        re0 = re_cnt;
        begin_txn();
        xfer(8'h8A, m); check("rd_miso0", 32'(m), 32'hA5);
        xfer(8'h00, m); check("rd_miso1", 32'(m), 32'h3C);
        xfer(8'h00, m); check("rd_miso2", 32'(m), 32'h4D);
        end_txn();
        check("rd_re_cnt", 32'(re_cnt - re0), 32'd3);
        check("rd_we_cnt", 32'(we_cnt - we0), 32'd0);

        // Address wrap 7F -> 00.
        begin_txn();
        xfer(8'h7F, m);
        xfer(8'h01, m);
        xfer(8'h02, m);
        end_txn();
        check("wrap_reg7f", 32'(regs[127]), 32'h01);
        check("wrap_reg00", 32'(regs[0]), 32'h02);

        // Requests while deselected are ignored.
        we0 = we_cnt;
        re0 = re_cnt;
        pulse(8'hFF);
        pulse(8'hFF);
        @(negedge clk);
        check("nosel_we", 32'(we_cnt - we0), 32'd0);
        check("nosel_re", 32'(re_cnt - re0), 32'd0);
        check("nosel_active", 32'(active), 32'h0);
        check("nosel_tx_hold", 32'(tx_byte), 32'h02);
        begin_txn();
        xfer(8'h00, m); check("nosel_still_idle", 32'(m), 32'hA5);
        end_txn();

        // Abort: partial byte after cmd 20 produces no request.
        we0 = we_cnt;
        begin_txn();
        xfer(8'h20, m);
        repeat (4) @(negedge clk);
        select = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_we", 32'(we_cnt - we0), 32'd0);
        check("abort_reg20", 32'(regs[32]), 32'h00);
        check("abort_active", 32'(active), 32'h0);

        // Request coinciding with deselect: deselect wins.
        begin_txn();
        xfer(8'h20, m);
        @(negedge clk);
        select  = 1'b0;
        request = 1'b1;
        rx_byte = 8'h55;
        @(negedge clk);
        request = 1'b0;
        repeat (2) @(negedge clk);
        check("coinc_we", 32'(we_cnt - we0), 32'd0);
        check("coinc_reg20", 32'(regs[32]), 32'h00);

        begin_txn();
        xfer(8'h20, m); check("abort2_miso0", 32'(m), 32'hA5);
        xfer(8'h77, m);
        end_txn();
        check("abort2_reg20", 32'(regs[32]), 32'h77);

        // Reset in the middle of a read of address 01.
        begin_txn();
        xfer(8'h01, m);
        xfer(8'hC3, m);
        end_txn();
        begin_txn();
        xfer(8'h81, m);
        check("prerst_tx", 32'(tx_byte), 32'hC3);
        check("prerst_active", 32'(active), 32'h1);
        #2;
        reset_n = 1'b0;
        request = 1'b1;
        #1;
        check("arst_tx", 32'(tx_byte), 32'h00);
        check("arst_active", 32'(active), 32'h0);
        check("arst_re", 32'(bus.reg_re), 32'h0);
        check("arst_we", 32'(bus.reg_we), 32'h0);
        @(negedge clk);
        request = 1'b0;
        select  = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        begin_txn();
        xfer(8'h00, m); check("postrst_miso0", 32'(m), 32'hA5);
        end_txn();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
